// File: rtl/avl_bus_arbiter_if.sv
// avl_bus_arbiter_if: per-master command/response bundle plus the shared-slave bus.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface avl_bus_arbiter_if #(
    parameter int MASTER_NUM  = 4,
    parameter int BURST_CNT_W = 8
);
    logic [32*MASTER_NUM-1:0]          m_address;
    logic [32*MASTER_NUM-1:0]          m_write_data;
    logic [4*MASTER_NUM-1:0]           m_byte_en;
    logic [BURST_CNT_W*MASTER_NUM-1:0] m_burst_count;
    logic [MASTER_NUM-1:0]             m_read;
    logic [MASTER_NUM-1:0]             m_write;
    logic [MASTER_NUM-1:0]             m_begin_burst_transfer;
    logic [MASTER_NUM-1:0]             m_request_ready;
    logic [31:0]                       m_read_data;
    logic [MASTER_NUM-1:0]             m_read_data_valid;
    logic [MASTER_NUM-1:0]             m_resp_ready;
    logic [31:0]                       s_address;
    logic [31:0]                       s_write_data;
    logic [3:0]                        s_byte_en;
    logic                              s_read;
    logic                              s_write;
    logic                              s_begin_burst_transfer;
    logic [BURST_CNT_W-1:0]            s_burst_count;
    logic                              s_request_ready;
    logic [31:0]                       s_read_data;
    logic                              s_read_data_valid;
    logic                              s_resp_ready;

    modport master (
        input  m_address, m_write_data, m_byte_en, m_burst_count, m_read, m_write,
               m_begin_burst_transfer, m_resp_ready, s_request_ready, s_read_data, s_read_data_valid,
        output m_request_ready, m_read_data, m_read_data_valid, s_address, s_write_data, s_byte_en,
               s_read, s_write, s_begin_burst_transfer, s_burst_count, s_resp_ready
    );

    modport slave (
        output m_address, m_write_data, m_byte_en, m_burst_count, m_read, m_write,
               m_begin_burst_transfer, m_resp_ready, s_request_ready, s_read_data, s_read_data_valid,
        input  m_request_ready, m_read_data, m_read_data_valid, s_address, s_write_data, s_byte_en,
               s_read, s_write, s_begin_burst_transfer, s_burst_count, s_resp_ready
    );
endinterface

// File: rtl/avl_bus_arbiter.sv
// avl_bus_arbiter: round-robin arbiter of MASTER_NUM masters onto one slave, with burst locking
// and an in-order ID FIFO that routes read responses back to the issuing master.
module avl_bus_arbiter #(
    parameter int MASTER_NUM      = 4,
    parameter int RESP_FIFO_DEPTH = 8,
    parameter int BURST_CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rest,
    avl_bus_arbiter_if.master bus,
    output logic              resp_err
);
    localparam int GW = $clog2(MASTER_NUM);
    localparam int AW = $clog2(RESP_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, OWN, BURST} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          g_q, g_d, rr_q, rr_d, g_inc, pick, head;
    logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]          fifo_q [RESP_FIFO_DEPTH];
    logic [AW-1:0]          wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]            occ_q, occ_d;
    logic                   err_q, err_d;
    logic                   own, full, empty, acc, push, pop;
    logic [MASTER_NUM-1:0]  req;

    assign req   = bus.m_read | bus.m_write;
    assign own   = state_q != IDLE;
    assign full  = occ_q == (AW+1)'(RESP_FIFO_DEPTH);
    assign empty = occ_q == '0;
    assign head  = fifo_q[rp_q];
    assign g_inc = (g_q == GW'(MASTER_NUM - 1)) ? '0 : g_q + GW'(1);

    always_comb begin
        bus.s_address              = own ? bus.m_address[32*int'(g_q) +: 32] : '0;
        bus.s_write_data           = own ? bus.m_write_data[32*int'(g_q) +: 32] : '0;
        bus.s_byte_en              = own ? bus.m_byte_en[4*int'(g_q) +: 4] : '0;
        bus.s_burst_count          = own ? bus.m_burst_count[BURST_CNT_W*int'(g_q) +: BURST_CNT_W] : '0;
        bus.s_begin_burst_transfer = own & bus.m_begin_burst_transfer[g_q];
        bus.s_read                 = own & bus.m_read[g_q] & ~full;
        bus.s_write                = own & bus.m_write[g_q];
    end

    assign acc                   = (bus.s_read | bus.s_write) & bus.s_request_ready;
    assign push                  = acc & bus.s_read;
    assign pop                   = bus.s_read_data_valid & bus.s_resp_ready & ~empty;
    assign bus.m_request_ready   = MASTER_NUM'(acc) << g_q;
    assign bus.m_read_data       = bus.s_read_data;
    assign bus.m_read_data_valid = MASTER_NUM'(bus.s_read_data_valid & ~empty) << head;
    // An orphan response is drained unconditionally so the slave never wedges.
    assign bus.s_resp_ready      = ~rest & (empty | bus.m_resp_ready[head]);
    assign resp_err              = err_q;

    // Descending scan so the lowest offset from rr_q wins.
    always_comb begin
        pick = '0;
        for (int k = MASTER_NUM - 1; k >= 0; k--)
            if (req[(int'(rr_q) + k) % MASTER_NUM]) pick = GW'((int'(rr_q) + k) % MASTER_NUM);
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (|req) begin
                g_d     = pick;
                state_d = OWN;
            end
            OWN: if (acc && bus.s_begin_burst_transfer && bus.s_burst_count != '0) begin
                cnt_d   = bus.s_burst_count;
                state_d = BURST;
            end else if (acc) begin
                rr_d    = g_inc;
                state_d = IDLE;
            end else if (!req[g_q]) begin
                state_d = IDLE;
            end
            BURST: if (acc) begin
                cnt_d = cnt_q - BURST_CNT_W'(1);
                if (cnt_q == BURST_CNT_W'(1)) begin
                    rr_d    = g_inc;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wp_d  = wp_q + AW'(push);
        rp_d  = rp_q + AW'(pop);
        occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
        err_d = err_q | (bus.s_read_data_valid & empty);
    end

    always_ff @(posedge clk or posedge rest)
        if (rest) begin
            state_q <= IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end

    always_ff @(posedge clk)
        if (push) fifo_q[wp_q] <= g_q;
endmodule

// File: tb/tb_avl_bus_arbiter.sv
// tb_avl_bus_arbiter: randomized masters and slave; a transaction-level round-robin model
// predicts every accepted beat and every routed read response, checked by a negedge monitor.
module tb_avl_bus_arbiter;
    localparam int NM = 4;
    localparam int DEPTH = 8;
    localparam int BW = 8;

    typedef struct packed {
        logic          rw;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [3:0]    be;
        logic [BW-1:0] bc;
        logic          bb;
    } txn_t;

    typedef struct {
        logic [127:0] v;
        int           m;
        logic         rw;
    } beat_t;

    logic clk, rest, resp_err;
    avl_bus_arbiter_if #(.MASTER_NUM(NM), .BURST_CNT_W(BW)) bus ();

    avl_bus_arbiter #(.MASTER_NUM(NM), .RESP_FIFO_DEPTH(DEPTH), .BURST_CNT_W(BW)) dut (
        .clk(clk),
        .rest(rest),
        .bus(bus.master),
        .resp_err(resp_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    txn_t  mq [NM][$];
    txn_t  batch [NM][$];
    int    beat [NM];
    beat_t exp_cmd [$];
    int    exp_rsp [$];
    int    n_pass = 0, n_tot = 0;
    int    sq = 0, n_rd = 0, mptr = 0, srr_pct = 100;
    bit    slave_hold = 0;

    task automatic chk(input string nm, input logic ok, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int nbeats(txn_t t);
        return (t.bb && t.bc != 0) ? int'(t.bc) + 1 : 1;
    endfunction

    function automatic logic [127:0] pack_cmd(logic [31:0] a, logic [31:0] d, logic [3:0] be, logic rd,
                                              logic wr, logic bb, logic [BW-1:0] bc, logic [NM-1:0] rr);
        return {45'b0, a, d, be, rd, wr, bb, bc, rr};
    endfunction

    function automatic bit busy();
        for (int i = 0; i < NM; i++) if (mq[i].size() != 0) return 1;
        return exp_cmd.size() != 0 || exp_rsp.size() != 0 || sq != 0;
    endfunction

    // Masters keep requesting while work is queued, so the grant order is a pure
    // round-robin walk over the issued transaction lists.
    task automatic issue();
        bit found;
        for (int i = 0; i < NM; i++) foreach (batch[i][j]) mq[i].push_back(batch[i][j]);
        do begin
            found = 0;
            for (int k = 0; k < NM && !found; k++) begin
                int i = (mptr + k) % NM;
                if (batch[i].size() != 0) begin
                    txn_t t = batch[i].pop_front();
                    for (int b = 0; b < nbeats(t); b++) begin
                        beat_t e;
                        e.v  = pack_cmd(t.addr + 32'(4 * b), t.data + 32'(b), t.be, !t.rw, t.rw, t.bb, t.bc, NM'(1 << i));
                        e.m  = i;
                        e.rw = t.rw;
                        exp_cmd.push_back(e);
                    end
                    mptr  = (i + 1) % NM;
                    found = 1;
                end
            end
        end while (found);
    endtask

    task automatic drive();
        for (int i = 0; i < NM; i++) begin
            if (mq[i].size() != 0) begin
                txn_t t = mq[i][0];
                bus.m_address[32*i +: 32]    = t.addr + 32'(4 * beat[i]);
                bus.m_write_data[32*i +: 32] = t.data + 32'(beat[i]);
                bus.m_byte_en[4*i +: 4]      = t.be;
                bus.m_burst_count[BW*i +: BW] = t.bc;
                bus.m_begin_burst_transfer[i] = t.bb;
                bus.m_read[i]  = !t.rw;
                bus.m_write[i] = t.rw;
            end else begin
                bus.m_read[i]  = 0;
                bus.m_write[i] = 0;
            end
        end
    endtask

    task automatic step();
        logic [NM-1:0] c_mrr;
        logic c_rd, c_hs;
        @(negedge clk);
        c_mrr = bus.m_request_ready;
        c_rd  = bus.s_read & bus.s_request_ready;
        c_hs  = bus.s_read_data_valid & bus.s_resp_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NM; i++)
            if (c_mrr[i] && mq[i].size() != 0) begin
                beat[i]++;
                if (beat[i] == nbeats(mq[i][0])) begin
                    void'(mq[i].pop_front());
                    beat[i] = 0;
                end
            end
        if (c_rd) begin
            n_rd++;
            sq++;
        end
        if (c_hs) begin
            bus.s_read_data_valid = 0;
            if (sq > 0) sq--;
        end
        if (!slave_hold && !bus.s_read_data_valid && sq > 0 && $urandom_range(1, 0) == 1) begin
            bus.s_read_data_valid = 1;
            bus.s_read_data = $urandom;
        end
        bus.s_request_ready = $urandom_range(99, 0) < srr_pct;
        bus.m_resp_ready = NM'($urandom);
        drive();
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy() && n < 6000) begin
            step();
            n++;
        end
        chk(nm, !busy(), 128'(busy()), 128'(0));
    endtask

    beat_t        e;
    int           rm;
    logic [127:0] r;

    always @(negedge clk) begin
        if (rest) begin
            r = {bus.s_address, bus.s_write_data, bus.s_byte_en, bus.s_read, bus.s_write,
                 bus.s_begin_burst_transfer, bus.s_burst_count, bus.m_request_ready,
                 bus.m_read_data_valid, bus.s_resp_ready, resp_err, bus.m_read_data ^ bus.s_read_data};
            chk("reset_outputs", r == '0, r, '0);
        end else begin
            if (bus.s_read_data_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk("orphan_route", bus.m_read_data_valid == 0 && bus.s_resp_ready,
                        {bus.m_read_data_valid, bus.s_resp_ready}, {NM'(0), 1'b1});
                end else begin
                    rm = exp_rsp[0];
                    chk("rsp_route",
                        {bus.m_read_data_valid, bus.m_read_data, bus.s_resp_ready} ==
                        {NM'(1 << rm), bus.s_read_data, bus.m_resp_ready[rm]},
                        {bus.m_read_data_valid, bus.m_read_data, bus.s_resp_ready},
                        {NM'(1 << rm), bus.s_read_data, bus.m_resp_ready[rm]});
                    if (bus.m_resp_ready[rm]) void'(exp_rsp.pop_front());
                end
            end
            if ((bus.s_read | bus.s_write) && bus.s_request_ready) begin
                if (exp_cmd.size() == 0) begin
                    chk("unexpected_beat", 0, {bus.s_address, bus.m_request_ready}, '0);
                end else begin
                    e = exp_cmd.pop_front();
                    r = pack_cmd(bus.s_address, bus.s_write_data, bus.s_byte_en, bus.s_read, bus.s_write,
                                 bus.s_begin_burst_transfer, bus.s_burst_count, bus.m_request_ready);
                    chk("beat", r == e.v, r, e.v);
                    if (!e.rw) exp_rsp.push_back(e.m);
                end
            end else if (bus.m_request_ready != 0) begin
                chk("ready_without_accept", 0, 128'(bus.m_request_ready), '0);
            end
        end
    end

    initial begin
        txn_t t;
        rest = 1;
        bus.m_address = '0;
        bus.m_write_data = '0;
        bus.m_byte_en = '0;
        bus.m_burst_count = '0;
        bus.m_begin_burst_transfer = '0;
        bus.m_read = '0;
        bus.m_write = '0;
        bus.m_resp_ready = '0;
        bus.s_request_ready = 0;
        bus.s_read_data = '0;
        bus.s_read_data_valid = 0;
        for (int i = 0; i < NM; i++) beat[i] = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.m_read = NM'($urandom);
            bus.m_write = NM'($urandom);
            bus.s_request_ready = 1;
            bus.s_read_data = $urandom;
            bus.s_read_data_valid = 1'($urandom);
            bus.m_resp_ready = NM'($urandom);
        end
        @(posedge clk);
        #1;
        rest = 0;
        bus.m_read = '0;
        bus.m_write = '0;
        bus.s_read_data_valid = 0;

        for (int p = 0; p < 4; p++) begin
            srr_pct = (p == 0) ? 100 : 90 - 20 * p;
            for (int i = 0; i < NM; i++)
                repeat ($urandom_range(4, 0)) begin
                    t.rw = 1'($urandom);
                    t.addr = $urandom & 32'hFFFF_FFFC;
                    t.data = $urandom;
                    t.be = 4'($urandom);
                    t.bc = BW'($urandom_range(3, 0));
                    t.bb = 1'($urandom);
                    batch[i].push_back(t);
                end
            issue();
            drive();
            wait_idle("drain_random");
        end

        srr_pct = 100;
        slave_hold = 1;
        for (int k = 0; k < 9; k++) batch[0].push_back('{1'b0, 32'h1000 + 32'(16 * k), 32'(k), 4'hF, BW'(0), 1'b0});
        issue();
        drive();
        n_rd = 0;
        for (int n = 0; n < 200 && n_rd < 8; n++) step();
        chk("fifo_fill", n_rd == 8, 128'(n_rd), 128'(8));
        repeat (4) step();
        @(negedge clk);
        chk("fifo_full_stall", !bus.s_read && bus.s_address == 32'h1080 && bus.m_request_ready == 0,
            {bus.s_read, bus.s_address, bus.m_request_ready}, {1'b0, 32'h1080, NM'(0)});
        slave_hold = 0;
        wait_idle("drain_full");

        slave_hold = 1;
        batch[1].push_back('{1'b0, 32'h2000, 32'h0, 4'hF, BW'(5), 1'b1});
        issue();
        drive();
        n_rd = 0;
        for (int n = 0; n < 100 && n_rd < 2; n++) step();
        chk("burst_two_beats", n_rd == 2, 128'(n_rd), 128'(2));
        rest = 1;
        for (int i = 0; i < NM; i++) begin
            mq[i].delete();
            beat[i] = 0;
        end
        exp_cmd.delete();
        exp_rsp.delete();
        sq = 0;
        mptr = 0;
        drive();
        repeat (3) step();
        rest = 0;
        repeat (4) step();
        bus.s_read_data_valid = 1;
        bus.s_read_data = 32'hDEAD_BEEF;
        step();
        @(negedge clk);
        chk("resp_err_set", resp_err == 1, 128'(resp_err), 128'(1));
        @(posedge clk);
        #1;
        rest = 1;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
